// File: rtl/vga_1bit_tx.sv
// 1-bit VGA serializer: divided pixel clock, h/v counters, registered syncs and colour.
// Latency: syncs/colour change on the edge that ends the pixel-fetch clock; no backpressure, an empty source flags underflow.
module vga_1bit_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic pix_valid,
    input  logic pix_data,
    output logic pix_ready,
    output logic h_sync,
    output logic v_sync,
    output logic color,
    output logic frame_start,
    output logic underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);
    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          run_q, run_d;
    logic          pix_ready_q, pix_ready_d;
    logic          frame_start_q, frame_start_d;
    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic          color_q, color_d;
    logic          underflow_q, underflow_d;

    logic          tick, pre_tick;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic          next_active, next_hs, next_vs;

    assign tick     = en && (div_q == DIV_LAST);
    assign pre_tick = en && (div_q == DIV_PRE);

    // The first tick after idle enters (0,0) instead of stepping past it.
    always_comb begin
        h_next = '0;
        v_next = '0;
        if (run_q) begin
            if (h_cnt_q == H_LAST) begin
                h_next = '0;
                v_next = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_next = h_cnt_q + 1'b1;
                v_next = v_cnt_q;
            end
        end
    end

    assign next_active = (h_next < H_ACT) && (v_next < V_ACT);
    assign next_hs     = (h_next >= H_SS) && (h_next <= H_SE);
    assign next_vs     = (v_next >= V_SS) && (v_next <= V_SE);

    always_comb begin
        div_d         = div_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        run_d         = run_q;
        pix_ready_d   = 1'b0;
        frame_start_d = 1'b0;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        color_d       = color_q;
        underflow_d   = underflow_q;
        if (!en) begin
            div_d    = '0;
            h_cnt_d  = '0;
            v_cnt_d  = '0;
            run_d    = 1'b0;
            h_sync_d = SYNC_OFF;
            v_sync_d = SYNC_OFF;
            color_d  = 1'b0;
        end else begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            // Strobes are raised one clock early so they occupy exactly the tick clock.
            if (pre_tick) begin
                pix_ready_d   = next_active;
                frame_start_d = (h_next == '0) && (v_next == '0);
            end
            if (tick) begin
                h_cnt_d  = h_next;
                v_cnt_d  = v_next;
                run_d    = 1'b1;
                h_sync_d = next_hs ? SYNC_ON : SYNC_OFF;
                v_sync_d = next_vs ? SYNC_ON : SYNC_OFF;
                color_d  = pix_ready_q && pix_valid && pix_data;
                if (pix_ready_q && !pix_valid) begin
                    underflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            run_q         <= 1'b0;
            pix_ready_q   <= 1'b0;
            frame_start_q <= 1'b0;
            h_sync_q      <= SYNC_OFF;
            v_sync_q      <= SYNC_OFF;
            color_q       <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            run_q         <= run_d;
            pix_ready_q   <= pix_ready_d;
            frame_start_q <= frame_start_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            color_q       <= color_d;
            underflow_q   <= underflow_d;
        end
    end

    assign pix_ready   = pix_ready_q;
    assign frame_start = frame_start_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign color       = color_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_1bit_tx.sv
// Bench for vga_1bit_tx: two reduced-geometry instances (active-low /4 and active-high /2)
// checked every clock against a clock-count pixel model.
module tb_vga_1bit_tx;

    localparam int HA = 6, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int DA = 4;
    localparam int DB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic pix_valid = 1'b1;
    logic pix_data = 1'b0;
    logic a_pix_ready, a_h_sync, a_v_sync, a_color, a_frame_start, a_underflow;
    logic b_pix_ready, b_h_sync, b_v_sync, b_color, b_frame_start, b_underflow;

    always #5 clk = ~clk;

    vga_1bit_tx #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                  .CLK_DIV(DA), .SYNC_POL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(a_pix_ready), .h_sync(a_h_sync), .v_sync(a_v_sync), .color(a_color),
        .frame_start(a_frame_start), .underflow(a_underflow));

    vga_1bit_tx #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                  .CLK_DIV(DB), .SYNC_POL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(b_pix_ready), .h_sync(b_h_sync), .v_sync(b_v_sync), .color(b_color),
        .frame_start(b_frame_start), .underflow(b_underflow));

    int n_chk = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;
    bit pat_on = 1'b0;
    bit hold_one = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at time %0t", nm, act, exp, $time);
    endtask

    // Pixel n counted from the frame origin maps to raster position (n mod HT, n/HT mod VT).
    function automatic bit f_act(input int n);
        return ((n % HT) < HA) && (((n / HT) % VT) < VA);
    endfunction
    function automatic bit f_hs(input int n);
        return ((n % HT) >= HA + HF) && ((n % HT) < HA + HF + HS);
    endfunction
    function automatic bit f_vs(input int n);
        return (((n / HT) % VT) >= VA + VF) && (((n / HT) % VT) < VA + VF + VS);
    endfunction
    function automatic bit f_org(input int n);
        return (n % (HT * VT)) == 0;
    endfunction

    // c = consecutive running clocks since idle; a clock with c%D==D-1 fetches pixel c/D.
    int ca = 0, cb = 0;
    bit cola = 1'b0, colb = 1'b0, ufa = 1'b0, ufb = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            ca = 0; cola = 1'b0; ufa = 1'b0;
            cb = 0; colb = 1'b0; ufb = 1'b0;
        end else if (!en) begin
            ca = 0; cola = 1'b0;
            cb = 0; colb = 1'b0;
        end else begin
            if (ca % DA == DA - 1) begin
                cola = f_act(ca / DA) && pix_valid && pix_data;
                if (f_act(ca / DA) && !pix_valid) ufa = 1'b1;
            end
            if (cb % DB == DB - 1) begin
                colb = f_act(cb / DB) && pix_valid && pix_data;
                if (f_act(cb / DB) && !pix_valid) ufb = 1'b1;
            end
            ca++;
            cb++;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_pix_ready", a_pix_ready, (ca % DA == DA - 1 && f_act(ca / DA)) ? 1 : 0);
            chk("a_frame_start", a_frame_start, (ca % DA == DA - 1 && f_org(ca / DA)) ? 1 : 0);
            chk("a_h_sync", a_h_sync, (ca >= DA && f_hs(ca / DA - 1)) ? 0 : 1);
            chk("a_v_sync", a_v_sync, (ca >= DA && f_vs(ca / DA - 1)) ? 0 : 1);
            chk("a_color", a_color, cola);
            chk("a_underflow", a_underflow, ufa);
            chk("b_pix_ready", b_pix_ready, (cb % DB == DB - 1 && f_act(cb / DB)) ? 1 : 0);
            chk("b_frame_start", b_frame_start, (cb % DB == DB - 1 && f_org(cb / DB)) ? 1 : 0);
            chk("b_h_sync", b_h_sync, (cb >= DB && f_hs(cb / DB - 1)) ? 1 : 0);
            chk("b_v_sync", b_v_sync, (cb >= DB && f_vs(cb / DB - 1)) ? 1 : 0);
            chk("b_color", b_color, colb);
            chk("b_underflow", b_underflow, ufb);
        end
    end

    // Data toggles every 4 clocks, i.e. once per pixel of the /4 instance.
    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_one) pix_data = 1'b1;
            else if (pat_on) begin
                k++;
                if (k % 4 == 0) pix_data = ~pix_data;
            end
        end
    end

    task automatic wait_fs(input string nm);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!a_frame_start && t < 2000);
        if (!a_frame_start) chk({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        int clks, prdy, hlow, vlow, bhigh, cnt, k;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_h_sync", a_h_sync, 1);
        chk("rst_a_v_sync", a_v_sync, 1);
        chk("rst_a_color", a_color, 0);
        chk("rst_a_pix_ready", a_pix_ready, 0);
        chk("rst_a_frame_start", a_frame_start, 0);
        chk("rst_a_underflow", a_underflow, 0);
        chk("rst_b_h_sync", b_h_sync, 0);
        chk("rst_b_v_sync", b_v_sync, 0);
        chk_on = 1'b1;

        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 en = 1'b1; pat_on = 1'b1;

        // Whole-frame statistics between two frame_start pulses of instance A.
        wait_fs("fs1");
        clks = 0; prdy = 0; hlow = 0; vlow = 0; bhigh = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i > 0 && a_frame_start) break;
            clks++;
            prdy  += int'(a_pix_ready);
            hlow  += int'(!a_h_sync);
            vlow  += int'(!a_v_sync);
            bhigh += int'(b_h_sync);
            @(negedge clk);
        end
        chk("frame_clocks", clks, HT * VT * DA);
        chk("frame_pix_ready", prdy, HA * VA);
        chk("frame_hsync_low", hlow, VT * HS * DA);
        chk("frame_vsync_low", vlow, VS * HT * DA);
        chk("b_hsync_high_2frames", bhigh, 2 * VT * HS * DB);

        // Starve the source for pixel (3,2) of A.
        hold_one = 1'b1;
        wait_fs("fs2");
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (a_pix_ready) begin
                cnt++;
                if (cnt == 2 * HA + 3) begin
                    pix_valid = 1'b0;
                    break;
                end
            end
        end
        chk("uf_reach_pixel", cnt, 2 * HA + 3);
        @(posedge clk); #1 pix_valid = 1'b1;
        @(negedge clk);
        chk("uf_color", a_color, 0);
        chk("uf_flag", a_underflow, 1);
        hold_one = 1'b0;

        // Drop enable mid-frame for 50 clocks.
        repeat (37) @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_h_sync", a_h_sync, 1);
        chk("idle_v_sync", a_v_sync, 1);
        chk("idle_color", a_color, 0);
        chk("idle_pix_ready", a_pix_ready, 0);
        chk("idle_uf_held", a_underflow, 1);
        repeat (49) @(posedge clk);
        #1 en = 1'b1;
        k = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            k++;
            if (a_frame_start) break;
        end
        chk("restart_fs_clock", k, DA);

        // One-clock reset while A is inside horizontal sync.
        k = 0;
        while (a_h_sync && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("reach_hsync", a_h_sync, 0);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_div", dut_a.div_q, 0);
        chk("rst_h_cnt", dut_a.h_cnt_q, 0);
        chk("rst_v_cnt", dut_a.v_cnt_q, 0);
        chk("rst_mid_h_sync", a_h_sync, 1);
        chk("rst_mid_v_sync", a_v_sync, 1);
        chk("rst_mid_underflow", a_underflow, 0);
        chk("rst_mid_b_h_sync", b_h_sync, 0);

        wait_fs("fs3");
        wait_fs("fs4");
        repeat (20) @(negedge clk);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_1bit_tx.md
VGA_1BIT_TX -- requirements
Module: vga_1bit_tx

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 The block SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 The block SHALL have parameter CLK_DIV, default 4, clk cycles per pixel; legal values are 2 or more.
REQ-010 The block SHALL have parameter SYNC_POL, default 0, asserted sync level; 0 means active-low.
REQ-011 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-012 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-013 The block SHALL have port en, input, 1 bit: run enable for the timing generator.
REQ-014 The block SHALL have port pix_valid, input, 1 bit: the upstream pixel source has data.
REQ-015 The block SHALL have port pix_data, input, 1 bit: monochrome pixel value.
REQ-016 The block SHALL have port pix_ready, output, 1 bit: pixel-fetch strobe.
REQ-017 The block SHALL have port h_sync, output, 1 bit: horizontal sync.
REQ-018 The block SHALL have port v_sync, output, 1 bit: vertical sync.
REQ-019 The block SHALL have port color, output, 1 bit: serial pixel bit, 0 outside the active region.
REQ-020 The block SHALL have port frame_start, output, 1 bit: one-clk pulse marking pixel (0,0).
REQ-021 The block SHALL have port underflow, output, 1 bit: sticky flag for a missed active pixel.

Function
REQ-022 The block SHALL run divider div from 0 to CLK_DIV-1, wrapping to 0, and assert internal tick when div equals CLK_DIV-1 and en is 1.
REQ-023 On each tick the block SHALL advance h_cnt (range 0..H_TOTAL-1, H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP); on an h_cnt wrap it SHALL advance v_cnt (range 0..V_TOTAL-1), which wraps to 0.
REQ-024 All counters SHALL size to the nearest clog2 width and SHALL compare with equality at terminal count, never relying on overflow.
REQ-025 The active region SHALL be h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-026 h_sync SHALL be asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); v_sync SHALL be asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-027 h_sync, v_sync and color SHALL be registered, SHALL update only on tick, and SHALL reflect the counter position entered on that tick, holding for CLK_DIV clocks.
REQ-028 pix_ready SHALL pulse high for exactly the tick clock whenever the position being entered is active; it SHALL be 0 at all other times.
REQ-029 A transfer SHALL occur when pix_ready and pix_valid are both 1; color SHALL then take pix_data.
REQ-030 If pix_ready=1 and pix_valid=0, color SHALL be 0 for that pixel and underflow SHALL set; underflow SHALL clear only on reset.
REQ-031 For positions outside the active region, color SHALL be 0, and pix_valid and pix_data SHALL be ignored.
REQ-032 frame_start SHALL pulse for the one clk on which position (0,0) is entered.
REQ-033 While en=0, div, h_cnt and v_cnt SHALL be 0; outputs SHALL be idle (syncs deasserted, color 0, pix_ready 0, frame_start 0).
REQ-034 On the en 0->1 edge the block SHALL treat the position held in reset as (0,0) and SHALL emit frame_start on the first tick, entering (0,0).
REQ-035 If en falls mid-frame, the block SHALL return to idle on the next clk and SHALL restart from (0,0) when en rises again; underflow SHALL be held.

Reset
REQ-036 When rst_n=0 at a clk edge, the block SHALL set div, h_cnt and v_cnt to 0.
REQ-037 When rst_n=0 at a clk edge, the block SHALL drive h_sync and v_sync to ~SYNC_POL.
REQ-038 When rst_n=0 at a clk edge, the block SHALL drive color, pix_ready, frame_start and underflow to 0.
REQ-039 Reset SHALL override en and any in-progress frame.

Verification
REQ-040 Defaults, en=1, pix_valid=1, pix_data alternating 1/0 -> bench SHALL check h_sync low for 96×4=384 clk every 800×4=3200 clk, v_sync low for 2 lines every 525 lines, 640 pix_ready pulses per active line and none in blanking, and color matching the accepted data.
REQ-041 pix_valid forced 0 for one active pixel at (100,10) -> bench SHALL check color=0 for that 4-clk pixel, underflow=1 from then until reset, and timing unchanged.
REQ-042 Run one full frame -> bench SHALL check frame_start pulses exactly once per 800×525×4=1,680,000 clk, coincident with the first pix_ready of the frame.
REQ-043 en dropped at (300,200), then raised 50 clk later -> bench SHALL check outputs idle on the next clk and frame_start after CLK_DIV clocks from the rise.
REQ-044 rst_n low for 1 clk mid-sync -> bench SHALL check all counters at 0, h_sync and v_sync equal to 1, and underflow=0 on the next clk.
REQ-045 SYNC_POL=1, CLK_DIV=2 -> bench SHALL check syncs active-high and each pixel held for 2 clk.
